// File: rtl/aes_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_block_sequencer
// Description : Streams data through the AES core one 128-bit block at a
//               time. Collects 16 bytes from the receive FIFO, starts the
//               core with a per-block latched mode, waits for the result and
//               drains 16 result bytes into the transmit FIFO.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous active-high reset (priority over abort)
//   key_ready      round keys available; only looked at in IDLE
//   mode_enc       1 = encrypt, 0 = decrypt; latched when a block starts
//   abort          synchronous flush of the block in flight
//   rx_empty       receive FIFO empty
//   rx_data        receive FIFO head byte (first-word fall-through)
//   rx_deq         pop receive FIFO
//   aes_ready      core can accept a block
//   aes_start      one-cycle start pulse to the core
//   aes_encrypt    latched mode presented to the core
//   aes_block_in   assembled block presented to the core
//   aes_done       one-cycle result-valid pulse from the core
//   aes_block_out  core result, valid with aes_done
//   tx_full        transmit FIFO full
//   tx_enq         push tx_data
//   tx_data        byte to the transmit FIFO
//   busy           high in any state except IDLE
//   blocks_done    completed-block count (wraps)
//   status         {UNLOAD, START|WAIT, LOAD, IDLE} one-hot
//
// Revision    : 1.0  initial release
// ============================================================================
module aes_block_sequencer #(
    parameter int BLOCK_BYTES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_ready,
    input  logic             mode_enc,
    input  logic             abort,
    input  logic             rx_empty,
    input  logic [7:0]       rx_data,
    output logic             rx_deq,
    input  logic             aes_ready,
    output logic             aes_start,
    output logic             aes_encrypt,
    output logic [127:0]     aes_block_in,
    input  logic             aes_done,
    input  logic [127:0]     aes_block_out,
    input  logic             tx_full,
    output logic             tx_enq,
    output logic [7:0]       tx_data,
    output logic             busy,
    output logic [CNT_W-1:0] blocks_done,
    output logic [3:0]       status
);

    // The byte index and shift registers are sized for a 128-bit core; any
    // other block size is meaningless here.
    generate
        if (BLOCK_BYTES != 16) begin : g_block_bytes_check
            $error("aes_block_sequencer: BLOCK_BYTES must be 16");
        end
    endgenerate

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_load   = 3'd1;
    localparam logic [2:0] c_st_start  = 3'd2;
    localparam logic [2:0] c_st_wait   = 3'd3;
    localparam logic [2:0] c_st_unload = 3'd4;

    localparam logic [3:0] c_last_idx = 4'd15;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [3:0]       r_idx;
    logic [127:0]     r_in_sr;
    logic [127:0]     r_out_sr;
    logic             r_mode;
    logic [CNT_W-1:0] r_blocks_done;

    // ------------------------------------------------------------------
    // Next-state values and strobes
    // ------------------------------------------------------------------
    logic [2:0]       w_state_nxt;
    logic [3:0]       w_idx_nxt;
    logic [127:0]     w_in_sr_nxt;
    logic [127:0]     w_out_sr_nxt;
    logic             w_mode_nxt;
    logic [CNT_W-1:0] w_blocks_done_nxt;
    logic             w_rx_deq;
    logic             w_aes_start;
    logic             w_tx_enq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_idx         <= 4'd0;
            r_in_sr       <= 128'd0;
            r_out_sr      <= 128'd0;
            r_mode        <= 1'b0;
            r_blocks_done <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_in_sr       <= w_in_sr_nxt;
            r_out_sr      <= w_out_sr_nxt;
            r_mode        <= w_mode_nxt;
            r_blocks_done <= w_blocks_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_in_sr_nxt       = r_in_sr;
        w_out_sr_nxt      = r_out_sr;
        w_mode_nxt        = r_mode;
        w_blocks_done_nxt = r_blocks_done;
        w_rx_deq          = 1'b0;
        w_aes_start       = 1'b0;
        w_tx_enq          = 1'b0;

        if (abort) begin
            // Flush: no strobes this cycle, block contents are abandoned and
            // the completed count is left alone. A late aes_done lands in
            // IDLE and is ignored there.
            w_state_nxt = c_st_idle;
            w_idx_nxt   = 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (key_ready && !rx_empty) begin
                        w_state_nxt = c_st_load;
                        w_mode_nxt  = mode_enc;
                        w_idx_nxt   = 4'd0;
                    end
                end

                c_st_load: begin
                    if (!rx_empty) begin
                        w_rx_deq = 1'b1;
                        // First byte ends up in the top byte of the block.
                        w_in_sr_nxt = {r_in_sr[119:0], rx_data};
                        w_idx_nxt   = r_idx + 4'd1;
                        if (r_idx == c_last_idx) begin
                            w_state_nxt = c_st_start;
                        end
                    end
                end

                c_st_start: begin
                    if (aes_ready) begin
                        w_aes_start = 1'b1;
                        w_state_nxt = c_st_wait;
                    end
                end

                c_st_wait: begin
                    if (aes_done) begin
                        w_out_sr_nxt = aes_block_out;
                        w_idx_nxt    = 4'd0;
                        w_state_nxt  = c_st_unload;
                    end
                end

                c_st_unload: begin
                    if (!tx_full) begin
                        w_tx_enq     = 1'b1;
                        w_out_sr_nxt = {r_out_sr[119:0], 8'h00};
                        w_idx_nxt    = r_idx + 4'd1;
                        if (r_idx == c_last_idx) begin
                            w_state_nxt       = c_st_idle;
                            w_blocks_done_nxt = r_blocks_done + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    w_state_nxt = c_st_idle;
                    w_idx_nxt   = 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The input shift register only moves in LOAD and the mode register only
    // loads on IDLE->LOAD, so both stay stable from START until the next block.
    assign rx_deq       = w_rx_deq;
    assign aes_start    = w_aes_start;
    assign tx_enq       = w_tx_enq;
    assign aes_encrypt  = r_mode;
    assign aes_block_in = r_in_sr;
    assign tx_data      = r_out_sr[127:120];
    assign busy         = (r_state != c_st_idle);
    assign blocks_done  = r_blocks_done;
    assign status       = {(r_state == c_st_unload),
                           (r_state == c_st_start) || (r_state == c_st_wait),
                           (r_state == c_st_load),
                           (r_state == c_st_idle)};

endmodule
`default_nettype wire

// File: tb/tb_aes_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_block_sequencer
// Description : Directed self-checking bench for aes_block_sequencer. Models
//               the Rx FIFO, a fixed-latency AES core and the Tx FIFO, and
//               compares strobes, block contents and result bytes against
//               hand-computed vectors.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aes_block_sequencer;

    localparam int CNT_W = 16;

    logic             tb_clk;
    logic             reset;
    logic             key_ready;
    logic             mode_enc;
    logic             abort;
    logic             rx_empty;
    logic [7:0]       rx_data;
    logic             rx_deq;
    logic             aes_ready;
    logic             aes_start;
    logic             aes_encrypt;
    logic [127:0]     aes_block_in;
    logic             aes_done;
    logic [127:0]     aes_block_out;
    logic             tx_full;
    logic             tx_enq;
    logic [7:0]       tx_data;
    logic             busy;
    logic [CNT_W-1:0] blocks_done;
    logic [3:0]       status;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_blocks = 0;
    logic [7:0] rx_mem [16];

    aes_block_sequencer #(
        .BLOCK_BYTES (16),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clk           (tb_clk),
        .reset         (reset),
        .key_ready     (key_ready),
        .mode_enc      (mode_enc),
        .abort         (abort),
        .rx_empty      (rx_empty),
        .rx_data       (rx_data),
        .rx_deq        (rx_deq),
        .aes_ready     (aes_ready),
        .aes_start     (aes_start),
        .aes_encrypt   (aes_encrypt),
        .aes_block_in  (aes_block_in),
        .aes_done      (aes_done),
        .aes_block_out (aes_block_out),
        .tx_full       (tx_full),
        .tx_enq        (tx_enq),
        .tx_data       (tx_data),
        .busy          (busy),
        .blocks_done   (blocks_done),
        .status        (status)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge and outputs are sampled 1 time unit
    // later, so the DUT always sees settled inputs at the rising edge.
    task automatic run_block(input string nm, input logic [127:0] in_blk,
                             input logic [127:0] out_blk, input logic mode0,
                             input int flip_at, input bit rx_toggle,
                             input int ready_low, input int full_at,
                             input int full_len, input int abort_at);
        int ptr = 0;
        int tptr = 0;
        int ndeq = 0;
        int nstart = 0;
        int cd = 0;
        int viol = 0;
        int cyc = 0;
        int first_deq = -1;
        int last_deq = -1;
        int start_cyc = -1;
        int rl = ready_low;
        int fl = full_len;
        bit aborted = 0;
        for (int i = 0; i < 16; i++) rx_mem[i] = in_blk[127-8*i -: 8];
        aes_block_out = out_blk;
        while (cyc < 400) begin
            @(negedge tb_clk);
            rx_empty = (ptr >= 16) || (rx_toggle && (cyc % 2 == 1));
            rx_data  = (ptr < 16) ? rx_mem[ptr] : 8'h00;
            mode_enc = (flip_at >= 0 && ptr >= flip_at) ? ~mode0 : mode0;
            aes_ready = 1'b1;
            if (status[2] && nstart == 0 && rl > 0) begin
                aes_ready = 1'b0;
                rl--;
            end
            tx_full = 1'b0;
            if (status[3] && tptr == full_at && fl > 0) begin
                tx_full = 1'b1;
                fl--;
            end
            aes_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) aes_done = 1'b1;
            end
            abort = (abort_at >= 0 && ptr == abort_at);
            #1;
            if (rx_deq && rx_empty) viol++;
            if (aes_start && !aes_ready) viol++;
            if (tx_enq && tx_full) viol++;
            if (abort) begin
                check({nm, "_abort_no_strobes"}, {rx_deq, aes_start, tx_enq}, 3'b000);
                aborted = 1;
                break;
            end
            if (rx_deq) begin
                if (first_deq < 0) first_deq = cyc;
                last_deq = cyc;
                ptr++;
                ndeq++;
            end
            if (aes_start) begin
                nstart++;
                start_cyc = cyc;
                check({nm, "_block_in"}, aes_block_in, in_blk);
                check({nm, "_encrypt"}, aes_encrypt, mode0);
                cd = 3;
            end
            if (tx_enq) begin
                check({nm, "_tx_byte"}, tx_data, out_blk[127-8*tptr -: 8]);
                tptr++;
            end
            cyc++;
            if (tptr == 16) break;
        end

        @(negedge tb_clk);
        abort    = 1'b0;
        rx_empty = 1'b1;
        aes_done = 1'b0;
        tx_full  = 1'b0;
        aes_ready = 1'b1;
        #1;
        check({nm, "_no_violations"}, viol, 0);
        if (!aborted) begin
            exp_blocks++;
            check({nm, "_deq_count"}, ndeq, 16);
            check({nm, "_start_count"}, nstart, 1);
            check({nm, "_tx_count"}, tptr, 16);
            if (!rx_toggle && ready_low == 0) begin
                check({nm, "_load_contiguous"}, last_deq - first_deq, 15);
                check({nm, "_start_after_load"}, start_cyc - last_deq, 1);
            end
        end
        check({nm, "_status_idle"}, status, 4'b0001);
        check({nm, "_busy"}, busy, 1'b0);
        check({nm, "_blocks_done"}, blocks_done, exp_blocks);
    endtask

    initial begin
        int deqs;
        reset = 1'b1;
        key_ready = 1'b0;
        mode_enc = 1'b0;
        abort = 1'b0;
        rx_empty = 1'b1;
        rx_data = 8'h00;
        aes_ready = 1'b0;
        aes_done = 1'b0;
        aes_block_out = 128'd0;
        tx_full = 1'b0;
        repeat (3) @(posedge tb_clk);
        @(negedge tb_clk);
        reset = 1'b0;
        #1;
        check("rst_status", status, 4'b0001);
        check("rst_strobes", {rx_deq, aes_start, tx_enq, busy}, 4'b0000);
        check("rst_blocks_done", blocks_done, 0);
        check("rst_block_in", aes_block_in, 128'd0);
        check("rst_tx_data_enc", {tx_data, aes_encrypt}, 9'd0);

        // Data waiting but no keys: nothing may be popped.
        deqs = 0;
        rx_empty = 1'b0;
        rx_data = 8'hAA;
        for (int i = 0; i < 6; i++) begin
            @(negedge tb_clk);
            #1;
            if (rx_deq) deqs++;
        end
        check("nokey_deq_count", deqs, 0);
        check("nokey_status", status, 4'b0001);
        rx_empty = 1'b1;
        key_ready = 1'b1;

        run_block("blk1", 128'h000102030405060708090A0B0C0D0E0F,
                  128'h69C4E0D86A7B0430D8CDB78070B4C55A, 1'b1, -1, 0, 0, -1, 0, -1);

        // Stray aes_done in IDLE is ignored.
        @(negedge tb_clk);
        aes_done = 1'b1;
        @(negedge tb_clk);
        aes_done = 1'b0;
        #1;
        check("stray_done_status", status, 4'b0001);
        check("stray_done_count", blocks_done, exp_blocks);

        run_block("blk2_stall", 128'h00112233445566778899AABBCCDDEEFF,
                  128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 1'b1, 4, 1, 5, 5, 3, -1);
        run_block("blk3_dec", 128'hFFEEDDCCBBAA99887766554433221100,
                  128'hFEDCBA98765432100123456789ABCDEF, 1'b0, -1, 0, 0, -1, 0, -1);
        run_block("blk4_abort", 128'h1111111111111111FFFFFFFFFFFFFFFF,
                  128'h22222222222222222222222222222222, 1'b1, -1, 0, 0, -1, 0, 8);
        run_block("blk5_fresh", 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF,
                  128'h5A5AA5A5C3C33C3C0102040810204080, 1'b1, -1, 0, 0, -1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
